// File: rtl/acs_array_if.sv
// acs_array_if: step-level bus between the branch-metric unit, the ACS array and traceback.
// master drives branch metrics in; slave (the ACS array) returns decisions and metrics.
interface acs_array_if #(
    parameter int unsigned K        = 3,
    parameter int unsigned BM_W     = 4,
    parameter int unsigned PM_W     = 8,
    parameter int unsigned TB_DEPTH = 8
);
    localparam int unsigned NUM_STATES = 1 << (K - 1);
    localparam int unsigned PTR_W      = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;

    logic                         valid_in;
    logic                         sof;
    logic [4*BM_W-1:0]            bm_in;
    logic                         valid_out;
    logic [NUM_STATES-1:0]        decisions;
    logic [PTR_W-1:0]             write_ptr_out;
    logic [NUM_STATES*PM_W-1:0]   path_metrics;
    logic [K-2:0]                 best_state;
    logic [PM_W-1:0]              best_metric;
    logic                         norm_flag;

    modport master (
        output valid_in, sof, bm_in,
        input  valid_out, decisions, write_ptr_out, path_metrics,
               best_state, best_metric, norm_flag
    );

    modport slave (
        input  valid_in, sof, bm_in,
        output valid_out, decisions, write_ptr_out, path_metrics,
               best_state, best_metric, norm_flag
    );
endinterface

// File: rtl/acs_array.sv
// acs_array: parametrised add-compare-select array for a rate-1/2 Viterbi decoder.
// Holds the path metrics, emits one survivor-decision vector per trellis step.
// Optional feature macro: ACS_NORM_EN (threshold metric normalisation).
module acs_array #(
    parameter int unsigned K        = 3,
    parameter int unsigned G0       = 7,
    parameter int unsigned G1       = 5,
    parameter int unsigned BM_W     = 4,
    parameter int unsigned PM_W     = 8,
    parameter int unsigned TB_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    acs_array_if.slave bus
);
    localparam int unsigned S_W        = K - 1;
    localparam int unsigned NUM_STATES = 1 << S_W;
    localparam int unsigned PTR_W      = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;
    localparam int unsigned PMV_W      = NUM_STATES * PM_W;
    localparam logic [K-1:0]    G0_V   = K'(G0);
    localparam logic [K-1:0]    G1_V   = K'(G1);
    localparam logic [PM_W-1:0] INIT   = PM_W'(1 << (PM_W - 2));

    // Known-start metric vector: state 0 certain, every other state equally unlikely.
    function automatic logic [PMV_W-1:0] start_metrics();
        logic [PMV_W-1:0] v;
        v = '0;
        for (int s = 1; s < NUM_STATES; s++) begin
            v[s*PM_W +: PM_W] = INIT;
        end
        return v;
    endfunction

    localparam logic [PMV_W-1:0] PM_START = start_metrics();

    // Encoder output {c0,c1} for leaving state s with input bit u.
    function automatic logic [1:0] codeword(input logic [S_W-1:0] s, input logic u);
        logic [K-1:0] e;
        e = {u, s};
        return {^(e & G0_V), ^(e & G1_V)};
    endfunction

    logic [PMV_W-1:0]      pm_q;
    logic [PMV_W-1:0]      prev_pm;
    logic [PMV_W-1:0]      new_pm;
    logic [PMV_W-1:0]      norm_pm;
    logic [NUM_STATES-1:0] dec_c;
    logic [NUM_STATES-1:0] dec_q;
    logic [PTR_W-1:0]      next_ptr_q;
    logic [PTR_W-1:0]      step_ptr;
    logic [PTR_W-1:0]      ptr_q;
    logic [PM_W-1:0]       min_pm;
    logic [PM_W-1:0]       best_metric_c;
    logic [PM_W-1:0]       best_metric_q;
    logic [S_W-1:0]        min_state;
    logic [S_W-1:0]        best_state_q;
    logic                  norm_c;
    logic                  norm_q;
    logic                  valid_q;

    // Frame start swaps in the known-start metrics and restarts the traceback column.
    // Reset leaves pm_q/next_ptr_q in exactly that state, so the first step after
    // reset behaves as a frame start without extra tracking.
    assign prev_pm  = bus.sof ? PM_START : pm_q;
    assign step_ptr = bus.sof ? '0 : next_ptr_q;

    for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
        localparam int unsigned P0  = (2 * g) % NUM_STATES;
        localparam int unsigned P1  = P0 + 1;
        localparam logic        U   = 1'(g >> (S_W - 1));
        localparam int unsigned CW0 = 32'(codeword(S_W'(P0), U));
        localparam int unsigned CW1 = 32'(codeword(S_W'(P1), U));

        logic [PM_W:0]   sum0;
        logic [PM_W:0]   sum1;
        logic [PM_W-1:0] cand0;
        logic [PM_W-1:0] cand1;
        logic [PM_W-1:0] sel_pm;
        logic            sel_dec;

        // Saturating add on both incoming branches, keep the smaller; ties go to p0.
        always_comb begin
            sum0    = {1'b0, prev_pm[P0*PM_W +: PM_W]} + (PM_W+1)'(bus.bm_in[CW0*BM_W +: BM_W]);
            sum1    = {1'b0, prev_pm[P1*PM_W +: PM_W]} + (PM_W+1)'(bus.bm_in[CW1*BM_W +: BM_W]);
            cand0   = sum0[PM_W] ? '1 : sum0[PM_W-1:0];
            cand1   = sum1[PM_W] ? '1 : sum1[PM_W-1:0];
            sel_pm  = cand0;
            sel_dec = 1'b0;
            if (cand1 < cand0) begin
                sel_pm  = cand1;
                sel_dec = 1'b1;
            end
        end

        assign new_pm[g*PM_W +: PM_W] = sel_pm;
        assign dec_c[g]               = sel_dec;
    end

    // Minimum of the new metrics; strict compare keeps the lowest index on ties.
    always_comb begin
        min_pm    = new_pm[PM_W-1:0];
        min_state = '0;
        for (int s = 1; s < NUM_STATES; s++) begin
            if (new_pm[s*PM_W +: PM_W] < min_pm) begin
                min_pm    = new_pm[s*PM_W +: PM_W];
                min_state = S_W'(s);
            end
        end
    end

`ifdef ACS_NORM_EN
    localparam logic [PM_W-1:0] HALF = PM_W'(1 << (PM_W - 1));

    // Once even the best path has crossed half range, pull every metric down by it.
    always_comb begin
        norm_c        = (min_pm >= HALF);
        norm_pm       = new_pm;
        best_metric_c = min_pm;
        if (norm_c) begin
            for (int s = 0; s < NUM_STATES; s++) begin
                norm_pm[s*PM_W +: PM_W] = new_pm[s*PM_W +: PM_W] - HALF;
            end
            best_metric_c = min_pm - HALF;
        end
    end
`else
    // No normalisation: metrics simply saturate at full scale.
    assign norm_c        = 1'b0;
    assign norm_pm       = new_pm;
    assign best_metric_c = min_pm;
`endif

    // Step registers: everything advances together on an accepted step and holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pm_q          <= PM_START;
            valid_q       <= 1'b0;
            dec_q         <= '0;
            ptr_q         <= '0;
            next_ptr_q    <= '0;
            best_state_q  <= '0;
            best_metric_q <= '0;
            norm_q        <= 1'b0;
        end else begin
            valid_q <= bus.valid_in;
            if (bus.valid_in) begin
                pm_q          <= norm_pm;
                dec_q         <= dec_c;
                ptr_q         <= step_ptr;
                next_ptr_q    <= (step_ptr == PTR_W'(TB_DEPTH - 1)) ? '0 : step_ptr + PTR_W'(1);
                best_state_q  <= min_state;
                best_metric_q <= best_metric_c;
                norm_q        <= norm_c;
            end
        end
    end

    assign bus.valid_out     = valid_q;
    assign bus.decisions     = dec_q;
    assign bus.write_ptr_out = ptr_q;
    assign bus.path_metrics  = pm_q;
    assign bus.best_state    = best_state_q;
    assign bus.best_metric   = best_metric_q;
    assign bus.norm_flag     = norm_q;
endmodule

// File: tb/tb_acs_array.sv
// tb_acs_array: table vectors, hand sequences and randomized steps against a trellis model.
module tb_acs_array;
    localparam int unsigned K        = 3;
    localparam int unsigned G0       = 7;
    localparam int unsigned G1       = 5;
    localparam int unsigned BM_W     = 4;
    localparam int unsigned PM_W     = 8;
    localparam int unsigned TB_DEPTH = 8;
    localparam int NS     = 4;
    localparam int PM_MAX = 255;
    localparam int INIT   = 64;

    typedef struct packed {
        logic        valid;
        logic        sof;
        logic [15:0] bm;
        logic        exp_valid;
        logic [31:0] exp_pm;
        logic [3:0]  exp_dec;
        logic [2:0]  exp_ptr;
        logic [1:0]  exp_bs;
        logic [7:0]  exp_bm;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    // reference model state
    int        m_pm [NS];
    int        m_ptr;
    logic      e_valid;
    logic [3:0] e_dec;
    int        e_ptr;
    int        e_bs;
    int        e_bm;
    logic      e_norm;

    acs_array_if #(.K(K), .BM_W(BM_W), .PM_W(PM_W), .TB_DEPTH(TB_DEPTH)) bus ();

    acs_array #(
        .K(K), .G0(G0), .G1(G1), .BM_W(BM_W), .PM_W(PM_W), .TB_DEPTH(TB_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_pm[i] = (i == 0) ? 0 : INIT;
        m_ptr   = 0;
        e_valid = 1'b0;
        e_dec   = '0;
        e_ptr   = 0;
        e_bs    = 0;
        e_bm    = 0;
        e_norm  = 1'b0;
    endtask

    // Forward trellis walk: every (state, input) pair feeds its successor.
    task automatic model_step(input logic v, input logic s, input logic [15:0] bm);
        int prev [NS];
        int nw [NS];
        int mn;
        int mi;
        e_valid = v;
        if (!v) return;
        for (int i = 0; i < NS; i++) begin
            prev[i] = s ? ((i == 0) ? 0 : INIT) : m_pm[i];
            nw[i]   = -1;
        end
        if (s) m_ptr = 0;
        for (int st = 0; st < NS; st++) begin
            for (int u = 0; u < 2; u++) begin
                int n;
                int e;
                int c0;
                int c1;
                int cand;
                n    = (u << (K - 2)) | (st >> 1);
                e    = (u << (K - 1)) | st;
                c0   = $countones(e & G0) % 2;
                c1   = $countones(e & G1) % 2;
                cand = prev[st] + int'(bm[(c0 * 2 + c1) * BM_W +: BM_W]);
                if (cand > PM_MAX) cand = PM_MAX;
                if (nw[n] < 0 || cand < nw[n]) begin
                    nw[n]    = cand;
                    e_dec[n] = (st % 2 == 1);
                end
            end
        end
        mn = nw[0];
        mi = 0;
        for (int i = 1; i < NS; i++) begin
            if (nw[i] < mn) begin
                mn = nw[i];
                mi = i;
            end
        end
        e_norm = 1'b0;
`ifdef ACS_NORM_EN
        if (mn >= 128) begin
            e_norm = 1'b1;
            for (int i = 0; i < NS; i++) nw[i] -= 128;
            mn -= 128;
        end
`endif
        e_bs  = mi;
        e_bm  = mn;
        e_ptr = m_ptr;
        m_ptr = (m_ptr + 1) % TB_DEPTH;
        for (int i = 0; i < NS; i++) m_pm[i] = nw[i];
    endtask

    task automatic check_model(input string tag);
        check_val({tag, ".valid_out"}, int'(bus.valid_out), int'(e_valid));
        check_val({tag, ".decisions"}, int'(bus.decisions), int'(e_dec));
        check_val({tag, ".write_ptr"}, int'(bus.write_ptr_out), e_ptr);
        check_val({tag, ".best_state"}, int'(bus.best_state), e_bs);
        check_val({tag, ".best_metric"}, int'(bus.best_metric), e_bm);
        check_val({tag, ".norm_flag"}, int'(bus.norm_flag), int'(e_norm));
        for (int i = 0; i < NS; i++) begin
            check_val($sformatf("%s.pm%0d", tag, i), int'(bus.path_metrics[i*PM_W +: PM_W]), m_pm[i]);
        end
    endtask

    // Present one input set (called right after a falling edge), check after the next.
    task automatic cycle(input logic v, input logic s, input logic [15:0] bm, input string tag);
        bus.valid_in = v;
        bus.sof      = s;
        bus.bm_in    = bm;
        if (rst) model_step(v, s, bm);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic check_all_pm(input string tag, input int exp);
        for (int i = 0; i < NS; i++) begin
            check_val($sformatf("%s.pm%0d", tag, i), int'(bus.path_metrics[i*PM_W +: PM_W]), exp);
        end
    endtask

    vec_t tbl [6];

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b0;
        bus.valid_in = 1'b0;
        bus.sof      = 1'b0;
        bus.bm_in    = '0;
        model_reset();

        tbl[0] = '{1'b1, 1'b1, 16'h4220, 1'b1, {8'd66, 8'd4, 8'd66, 8'd0}, 4'b0000, 3'd0, 2'd0, 8'd0};
        tbl[1] = '{1'b1, 1'b0, 16'h2103, 1'b1, {8'd4, 8'd2, 8'd5, 8'd3},   4'b0000, 3'd1, 2'd2, 8'd2};
        tbl[2] = '{1'b1, 1'b0, 16'h0055, 1'b1, {8'd4, 8'd3, 8'd2, 8'd5},   4'b1001, 3'd2, 2'd1, 8'd2};
        tbl[3] = '{1'b0, 1'b1, 16'hFFFF, 1'b0, {8'd4, 8'd3, 8'd2, 8'd5},   4'b1001, 3'd2, 2'd1, 8'd2};
        tbl[4] = '{1'b1, 1'b0, 16'h1111, 1'b1, {8'd4, 8'd3, 8'd4, 8'd3},   4'b0101, 3'd3, 2'd0, 8'd3};
        tbl[5] = '{1'b1, 1'b0, 16'h0101, 1'b1, {8'd3, 8'd3, 8'd4, 8'd4},   4'b0000, 3'd4, 2'd2, 8'd3};

        // reset state, then release with no traffic
        repeat (2) @(negedge clk);
        check_model("reset");
        check_val("reset.pm_flat", int'(bus.path_metrics), 32'h40404000);
        rst = 1'b1;
        @(negedge clk);
        check_model("idle_after_reset");

        // table vectors
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].valid, tbl[i].sof, tbl[i].bm, $sformatf("tbl%0d", i));
            check_val($sformatf("tbl%0d.valid", i), int'(bus.valid_out), int'(tbl[i].exp_valid));
            check_val($sformatf("tbl%0d.pm", i), int'(bus.path_metrics), int'(tbl[i].exp_pm));
            check_val($sformatf("tbl%0d.dec", i), int'(bus.decisions), int'(tbl[i].exp_dec));
            check_val($sformatf("tbl%0d.ptr", i), int'(bus.write_ptr_out), int'(tbl[i].exp_ptr));
            check_val($sformatf("tbl%0d.bs", i), int'(bus.best_state), int'(tbl[i].exp_bs));
            check_val($sformatf("tbl%0d.bm", i), int'(bus.best_metric), int'(tbl[i].exp_bm));
        end

        // gap: 1,0,0,1 with metrics and pointer holding
        cycle(1'b1, 1'b0, 16'h3021, "gap0");
        cycle(1'b0, 1'b0, 16'h7777, "gap1");
        cycle(1'b0, 1'b1, 16'h8888, "gap2");
        check_val("gap2.ptr_hold", int'(bus.write_ptr_out), 5);
        cycle(1'b1, 1'b0, 16'h1234, "gap3");
        check_val("gap3.ptr", int'(bus.write_ptr_out), 6);

        // normalisation / saturation with all branch metrics at 15
        cycle(1'b1, 1'b1, 16'hFFFF, "norm1");
        for (int n = 2; n <= 18; n++) begin
            cycle(1'b1, 1'b0, 16'hFFFF, $sformatf("norm%0d", n));
            if (n <= 8) check_all_pm($sformatf("norm_hand%0d", n), 15 * n);
            if (n == 9) begin
                check_val("norm9.dec", int'(bus.decisions), 0);
`ifdef ACS_NORM_EN
                check_all_pm("norm9_hand", 7);
                check_val("norm9.flag", int'(bus.norm_flag), 1);
`else
                check_all_pm("norm9_hand", 135);
                check_val("norm9.flag", int'(bus.norm_flag), 0);
`endif
            end
`ifndef ACS_NORM_EN
            if (n >= 17) check_all_pm($sformatf("sat%0d", n), 255);
`endif
        end

        // pointer wrap over ten steps
        cycle(1'b1, 1'b1, 16'h0123, "wrap0");
        check_val("wrap0.ptr", int'(bus.write_ptr_out), 0);
        for (int i = 1; i < 10; i++) begin
            cycle(1'b1, 1'b0, 16'($urandom), $sformatf("wrap%0d", i));
            check_val($sformatf("wrap%0d.ptr", i), int'(bus.write_ptr_out), i % 8);
        end
        // sof on the sixth step restarts the column
        cycle(1'b1, 1'b1, 16'h2222, "rs1");
        for (int i = 2; i <= 7; i++) begin
            cycle(1'b1, (i == 6), 16'($urandom), $sformatf("rs%0d", i));
            check_val($sformatf("rs%0d.ptr", i), int'(bus.write_ptr_out), (i < 6) ? i - 1 : i - 6);
        end

        // async reset between edges aborts the frame
        cycle(1'b1, 1'b0, 16'h5a5a, "pre_rst");
        bus.valid_in = 1'b1;
        bus.bm_in    = 16'h9999;
        #2 rst = 1'b0;
        #1;
        check_val("async.valid_out", int'(bus.valid_out), 0);
        check_val("async.decisions", int'(bus.decisions), 0);
        check_val("async.ptr", int'(bus.write_ptr_out), 0);
        check_val("async.best_state", int'(bus.best_state), 0);
        check_val("async.best_metric", int'(bus.best_metric), 0);
        check_val("async.norm", int'(bus.norm_flag), 0);
        check_val("async.pm", int'(bus.path_metrics), 32'h40404000);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 1'b0, 16'h4220, "post_rst");
        check_val("post_rst.pm", int'(bus.path_metrics), 32'h42044200);
        check_val("post_rst.ptr", int'(bus.write_ptr_out), 0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                  16'($urandom), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
